// File: rtl/spram_access_ctrl.sv
// spram_access_ctrl
//   Arbitrates read and write requests onto one external single-port RAM. The
//   RAM has a two-cycle read latency. Read data returns in request order through
//   a small response buffer. Reads are limited by credits so that every
//   in-flight read always has a free buffer slot.
//
//   Build option: define SPRAM_RR_ARB_EN to select round-robin arbitration when
//   both request types are valid. Without it, a write always wins and a read is
//   accepted only in cycles with wr_valid low.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   wr_valid/ready/addr/data   write request channel
//   rd_valid/ready/addr        read request channel
//   rsp_valid/ready/data       read response channel (in order)
//   ram_din/addr/wr_en         registered drive to the RAM
//   ram_dout                   RAM read data, valid 2 cycles after ram_addr
module spram_access_ctrl #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int RAM_DEPTH    = 256,
  parameter  int RSP_DEPTH    = 4,
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [LB_RAM_DEPTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [LB_RAM_DEPTH-1:0] rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [LB_RAM_DEPTH-1:0] ram_addr,
  output logic                    ram_wr_en,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);
  localparam int PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW     = $clog2(RSP_DEPTH + 1);
  localparam int STAGES = 3;

  logic [LB_RAM_DEPTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
  logic                    ram_wr_en_q, ram_wr_en_d;
  logic [STAGES-1:0]       vld_pipe_q, vld_pipe_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

  logic rd_wins, rd_acc, wr_acc, push, pop;

`ifdef SPRAM_RR_ARB_EN
  // 1 = the last contended grant went to the read side.
  logic last_rd_q, last_rd_d;
  assign rd_wins = !last_rd_q;
`else
  assign rd_wins = 1'b0;
`endif

  // rd_ready already includes the arbitration result. Because of this, a
  // wr/rd handshake pair can never both complete in the same cycle.
  assign rd_ready  = !rst && (credit_q != CW'(RSP_DEPTH)) && (!wr_valid || rd_wins);
  assign rd_acc    = rd_valid && rd_ready;
  assign wr_ready  = !rst && !rd_acc;
  assign wr_acc    = wr_valid && wr_ready;

  assign rsp_valid = !rst && (cnt_q != '0);
  assign rsp_data  = buf_q[rd_ptr_q];
  assign push      = vld_pipe_q[STAGES-1];
  assign pop       = rsp_valid && rsp_ready;

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_wr_en = ram_wr_en_q;

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_wr_en_d = wr_acc;
    if (wr_acc) begin
      ram_addr_d = wr_addr;
      ram_din_d  = wr_data;
    end else if (rd_acc) begin
      ram_addr_d = rd_addr;
    end

    // The read tag arrives at the last stage on the edge where ram_dout
    // carries that read's data.
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], rd_acc};

    // A credit is reserved when a read is accepted. It is released only when
    // the response is popped. Moving a read from in flight into the buffer
    // leaves the credit count unchanged.
    credit_d = credit_q + CW'(rd_acc) - CW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      buf_d[wr_ptr_q] = ram_dout;
      wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

`ifdef SPRAM_RR_ARB_EN
    last_rd_d = last_rd_q;
    if (wr_valid && rd_valid && (wr_acc || rd_acc)) last_rd_d = rd_acc;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_wr_en_q <= 1'b0;
      vld_pipe_q  <= '0;
      credit_q    <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
`ifdef SPRAM_RR_ARB_EN
      last_rd_q   <= 1'b0;
`endif
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_wr_en_q <= ram_wr_en_d;
      vld_pipe_q  <= vld_pipe_d;
      credit_q    <= credit_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
`ifdef SPRAM_RR_ARB_EN
      last_rd_q   <= last_rd_d;
`endif
    end
  end

  // The buffer contents are qualified by cnt_q, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Testbench for spram_access_ctrl.
// A behavioural RAM with a two-cycle read latency is connected to the DUT.
// Expected read data is pushed into a queue when each read is accepted. A
// monitor pops the queue and checks each response as it is handed off.
module tb_spram_access_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] ram_din, ram_addr, ram_dout;
  logic       ram_wr_en;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spram_access_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_dout(ram_dout)
  );

  // Behavioural RAM: the address is sampled on the first edge and the data
  // appears on the second edge. A read in the same cycle as a write sees the
  // old contents.
  logic [7:0] mem [256];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_din;
    rd1      <= mem[ram_addr];
    ram_dout <= rd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Monitor. It samples 2 time units after the negative edge, after the
  // driver has settled its inputs.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  always @(negedge clk) begin
    #2;
    if (rst) hold_v = 1'b0;
    else begin
      if (hold_v && rsp_valid) chk("rsp_hold", rsp_data, hold_d);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got 0x%0h, want no response", rsp_data);
        end else begin
          chk("rsp_data", rsp_data, exp_q.pop_front());
        end
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_d = rsp_data;
    end
  end

  // These tasks start on a negative edge and return on the negative edge just
  // after the accepting rising edge.
  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("wr_accept", wr_ready, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("ram_wr_en", ram_wr_en, 1'b1);
    chk("ram_addr_wr", ram_addr, a);
    chk("ram_din", ram_din, d);
  endtask

  task automatic do_rd(input logic [7:0] a, input logic [7:0] e);
    int n = 0;
    rd_valid = 1'b1; rd_addr = a;
    #1;
    while (!rd_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("rd_accept", rd_ready, 1'b1);
    if (rd_ready) exp_q.push_back(e);
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  logic [7:0] a6 [8] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h45, 8'h45};
  logic [7:0] e6 [8] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h85, 8'h85};
`ifdef SPRAM_RR_ARB_EN
  logic [7:0] g_exp [4] = '{"R", "W", "R", "W"};
`else
  logic [7:0] g_exp [4] = '{"W", "W", "W", "W"};
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    int k;
    logic [7:0] g;
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_wr_en", ram_wr_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("post_rst_rd_ready", rd_ready, 1);
    @(negedge clk);

    // Read-after-write and the exact response latency.
    do_wr(8'h10, 8'hA5);
    do_rd(8'h10, 8'hA5);
    #1; chk("lat0", rsp_valid, 0);
    @(negedge clk); #1; chk("lat1", rsp_valid, 0);
    chk("idle_wr_en", ram_wr_en, 0);
    chk("idle_addr_hold", ram_addr, 8'h10);
    @(negedge clk); #1; chk("lat2", rsp_valid, 0);
    @(negedge clk); #1; chk("lat3", rsp_valid, 1);
    @(negedge clk);

    // Write-after-read returns the old data. A later read returns the new data.
    do_wr(8'h20, 8'h11);
    do_rd(8'h20, 8'h11);
    do_wr(8'h20, 8'h22);
    do_rd(8'h20, 8'h22);

    // Top address.
    do_wr(8'hFF, 8'hFF);
    do_rd(8'hFF, 8'hFF);
    drain();

    // Credit limit: with the response side stalled, only 4 reads are accepted.
    for (int i = 0; i < 6; i++) do_wr(a6[i], e6[i]);
    rsp_ready = 1'b0; rd_valid = 1'b1; k = 0;
    for (int c = 0; c < 8; c++) begin
      rd_addr = a6[k]; #1;
      if (rd_ready && k < 6) begin exp_q.push_back(e6[k]); k++; end
      @(negedge clk);
    end
    rd_addr = a6[k]; #1;
    chk("credit_acc", k, 4);
    chk("credit_rd_ready", rd_ready, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk); rd_addr = a6[k]; #1;
      if (rd_ready) begin exp_q.push_back(e6[k]); k++; end
    end
    @(negedge clk);
    rd_valid = 1'b0;
    chk("credit_all_acc", k, 6);
    drain();

    // Contention arbitration.
    wr_valid = 1'b1; rd_valid = 1'b1; rd_addr = 8'h10;
    for (int c = 0; c < 4; c++) begin
      wr_addr = 8'h50 + 8'(c); wr_data = 8'h90 + 8'(c); #1;
      g = rd_ready ? "R" : (wr_ready ? "W" : "-");
      if (rd_ready) exp_q.push_back(8'hA5);
      chk("grant", g, g_exp[c]);
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    drain();

    // Reset one cycle after two reads are accepted discards both reads.
    rd_valid = 1'b1; rd_addr = 8'h10; #1;
    chk("mid_rd0", rd_ready, 1);
    @(negedge clk); #1;
    chk("mid_rd1", rd_ready, 1);
    @(negedge clk);
    rd_valid = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rd_ready", rd_ready, 0);
    rst = 1'b0; #1;
    chk("mid_post_rd_ready", rd_ready, 1);
    chk("mid_post_wr_ready", wr_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk("mid_no_rsp", rsp_valid, 0);
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
